// File: rtl/trng_ctrl_pkg.sv
// trng_ctrl_pkg
//   Shared definitions for the COSO TRNG run controller: PC command codes,
//   the status-reply header byte and the controller state encoding.
package trng_ctrl_pkg;

  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_ABORT  = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] STAT_HDR   = 8'h53;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_WARMUP,
    ST_RUN,
    ST_STAT
  } run_state_e;

endpackage

// File: rtl/warmup_timer.sv
// warmup_timer
//   Oscillator warm-up timer. A start pulse loads a down-counter; done is
//   asserted for exactly one cycle WARMUP_CYCLES cycles after the start edge.
//   clear abandons a warm-up in progress.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   start     load the counter and begin timing
//   clear     stop timing (abort)
//   done      one-cycle terminal-count indication
module warmup_timer #(
  parameter int WARMUP_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic done
);

  localparam int TW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  logic [TW-1:0] cnt;
  logic          running;

  // Loaded with WARMUP_CYCLES-1 so that terminal count is seen on the
  // WARMUP_CYCLES-th edge after start.
  assign done = running && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= TW'(WARMUP_CYCLES - 1);
      running <= 1'b1;
    end else if (done) begin
      running <= 1'b0;
    end else if (running) begin
      cnt <= cnt - TW'(1);
    end
  end

endmodule

// File: rtl/trng_run_ctrl.sv
// trng_run_ctrl
//   Run controller for the COSO TRNG performance path. Decodes PC commands,
//   warms up the oscillators, streams exactly N packed bytes to the UART and
//   answers status requests, sharing the single UART transmitter.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   rx_byte/rx_valid command bytes from the UART receiver
//   is_transmitting  UART busy
//   pack_byte/pack_transmit  packed random byte strobe from the packer
//   tx_byte/transmit byte + one-cycle strobe to the UART
//   pack_busy        hold to the packer
//   pack_rst         synchronous reset to the packer
//   trng_en          oscillator / sampler enable
//   run_active       high during WARMUP and RUN
//
// state   | meaning
// IDLE    | waiting for a command, TRNG off, packer held in reset
// LEN_HI  | next rx byte is length[15:8]
// LEN_LO  | next rx byte is length[7:0]; zero length returns to IDLE
// WARMUP  | oscillators running, packer in reset until timer done
// RUN     | forwarding packer bytes until remaining reaches zero
// STAT    | sending STAT_HDR, sent_cnt[15:8], sent_cnt[7:0]
module trng_run_ctrl
  import trng_ctrl_pkg::*;
#(
  parameter int WARMUP_CYCLES = 1024,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       is_transmitting,
  input  logic [7:0] pack_byte,
  input  logic       pack_transmit,
  output logic [7:0] tx_byte,
  output logic       transmit,
  output logic       pack_busy,
  output logic       pack_rst,
  output logic       trng_en,
  output logic       run_active
);

  run_state_e       state;
  logic [7:0]       len_hi;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] sent_cnt;
  logic [1:0]       stat_idx;
  logic [CNT_W-1:0] len_val;
  logic [15:0]      sent16;
  logic [7:0]       stat_byte;
  logic             rx_abort;
  logic             warm_start;
  logic             warm_clear;
  logic             warm_done;

  assign len_val    = CNT_W'({len_hi, rx_byte});
  assign sent16     = 16'(sent_cnt);
  assign rx_abort   = rx_valid && (rx_byte == CMD_ABORT);
  assign warm_start = (state == ST_LEN_LO) && rx_valid && (len_val != '0);
  assign warm_clear = (state == ST_WARMUP) && rx_abort;

  // The packer is held off outside RUN and for the cycle of our own strobe,
  // which also guarantees at least two cycles between transmit pulses.
  assign pack_busy  = (state != ST_RUN) || is_transmitting || transmit;
  assign run_active = (state == ST_WARMUP) || (state == ST_RUN);

  always_comb begin
    stat_byte = STAT_HDR;
    case (stat_idx)
      2'd1:    stat_byte = sent16[15:8];
      2'd2:    stat_byte = sent16[7:0];
      default: stat_byte = STAT_HDR;
    endcase
  end

  warmup_timer #(
    .WARMUP_CYCLES(WARMUP_CYCLES)
  ) u_warmup_timer (
    .clk  (clk),
    .rst  (rst),
    .start(warm_start),
    .clear(warm_clear),
    .done (warm_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx_byte   <= 8'h00;
      transmit  <= 1'b0;
      trng_en   <= 1'b0;
      pack_rst  <= 1'b1;
      len_hi    <= 8'h00;
      remaining <= '0;
      sent_cnt  <= '0;
      stat_idx  <= 2'd0;
    end else begin
      transmit <= 1'b0;
      case (state)
        ST_IDLE: begin
          trng_en  <= 1'b0;
          pack_rst <= 1'b1;
          if (rx_valid) begin
            if (rx_byte == CMD_START) begin
              state <= ST_LEN_HI;
            end else if (rx_byte == CMD_STATUS) begin
              state    <= ST_STAT;
              stat_idx <= 2'd0;
            end
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) begin
            len_hi <= rx_byte;
            state  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (rx_valid) begin
            remaining <= len_val;
            sent_cnt  <= '0;
            if (len_val == '0) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_WARMUP;
              trng_en <= 1'b1;
            end
          end
        end
        ST_WARMUP: begin
          if (rx_abort) begin
            state     <= ST_IDLE;
            trng_en   <= 1'b0;
            pack_rst  <= 1'b1;
            remaining <= '0;
          end else if (warm_done) begin
            state    <= ST_RUN;
            pack_rst <= 1'b0;
          end
        end
        ST_RUN: begin
          if (rx_abort) begin
            state     <= ST_IDLE;
            trng_en   <= 1'b0;
            pack_rst  <= 1'b1;
            remaining <= '0;
          end else if (pack_transmit && !pack_busy && (remaining != '0)) begin
            tx_byte   <= pack_byte;
            transmit  <= 1'b1;
            remaining <= remaining - CNT_W'(1);
            if (sent_cnt != '1) sent_cnt <= sent_cnt + CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state    <= ST_IDLE;
              trng_en  <= 1'b0;
              pack_rst <= 1'b1;
            end
          end
        end
        ST_STAT: begin
          if (rx_abort) begin
            state     <= ST_IDLE;
            remaining <= '0;
          end else if (!is_transmitting && !transmit) begin
            tx_byte  <= stat_byte;
            transmit <= 1'b1;
            if (stat_idx == 2'd2) begin
              state    <= ST_IDLE;
              stat_idx <= 2'd0;
            end else begin
              stat_idx <= stat_idx + 2'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_run_ctrl.sv
module tb_trng_run_ctrl;

  localparam int WARM = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       is_transmitting;
  logic [7:0] pack_byte;
  logic       pack_transmit;
  logic [7:0] tx_byte;
  logic       transmit;
  logic       pack_busy;
  logic       pack_rst;
  logic       trng_en;
  logic       run_active;
  logic       force_busy;

  int vectors = 0;
  int miscompares = 0;

  // UART / monitor model state
  int cyc = 0;
  int busy_left = 0;
  int last_tx_cyc = -100;
  int spacing_err = 0;
  int busy_err = 0;
  logic [7:0] act_q[$];

  // Reference model: expected output stream and counters
  logic [7:0] exp_q[$];
  int model_rem = 0;
  int model_sent = 0;

  assign is_transmitting = force_busy || (busy_left != 0);

  always #5 clk = ~clk;

  trng_run_ctrl #(
    .WARMUP_CYCLES(WARM),
    .CNT_W(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_byte        (rx_byte),
    .rx_valid       (rx_valid),
    .is_transmitting(is_transmitting),
    .pack_byte      (pack_byte),
    .pack_transmit  (pack_transmit),
    .tx_byte        (tx_byte),
    .transmit       (transmit),
    .pack_busy      (pack_busy),
    .pack_rst       (pack_rst),
    .trng_en        (trng_en),
    .run_active     (run_active)
  );

  // UART: captures every transmit pulse, then stays busy a few cycles.
  always @(negedge clk) begin
    cyc++;
    if (transmit) begin
      act_q.push_back(tx_byte);
      if (cyc - last_tx_cyc < 2) spacing_err++;
      if (is_transmitting) busy_err++;
      last_tx_cyc = cyc;
      busy_left = 2 + int'($urandom_range(0, 3));
    end else if (busy_left != 0) begin
      busy_left--;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic start_run(input logic [15:0] len);
    send_rx(8'h01);
    send_rx(len[15:8]);
    send_rx(len[7:0]);
    model_rem  = int'(len);
    model_sent = 0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (pack_rst === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("warmup_wait", {31'd0, pack_rst}, 32'd0);
  endtask

  // Well-behaved packer: waits for pack_busy low, strobes one byte.
  task automatic send_pack(input logic [7:0] b);
    int n = 0;
    while (pack_busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("pack_busy_wait", {31'd0, pack_busy}, 32'd0);
    pack_byte     = b;
    pack_transmit = 1'b1;
    tick();
    pack_transmit = 1'b0;
    if (model_rem > 0) begin
      exp_q.push_back(b);
      model_rem--;
      if (model_sent < 16'hFFFF) model_sent++;
      check("tx_strobe", {31'd0, transmit}, 32'd1);
      check("tx_data", {24'd0, tx_byte}, {24'd0, b});
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_trng_en"}, {31'd0, trng_en}, 32'd0);
    check({tag, "_pack_rst"}, {31'd0, pack_rst}, 32'd1);
    check({tag, "_run_active"}, {31'd0, run_active}, 32'd0);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check({tag, "_byte"}, {24'd0, act_q[i]}, {24'd0, exp_q[i]});
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic do_status(input string tag);
    int n = 0;
    logic [15:0] s;
    s = 16'(model_sent);
    send_rx(8'h03);
    exp_q.push_back(8'h53);
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
    while (act_q.size() < 3 && n < 100) begin
      tick();
      n++;
    end
    repeat (6) tick();
    check_stream(tag);
  endtask

  initial begin
    logic [15:0] len;
    int nb;
    int seen;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    pack_transmit = 1'b0;
    pack_byte = 8'h00;
    force_busy = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    check("rst_transmit", {31'd0, transmit}, 32'd0);
    check("rst_pack_busy", {31'd0, pack_busy}, 32'd1);
    check_idle("rst");
    rst = 1'b0;
    repeat (2) tick();

    // Basic run of 4 bytes, warm-up length
    start_run(16'h0004);
    check("a_trng_en_rise", {31'd0, trng_en}, 32'd1);
    check("a_run_active", {31'd0, run_active}, 32'd1);
    nb = 0;
    while (pack_rst === 1'b1 && nb < 50) begin
      tick();
      nb++;
    end
    check("a_warmup_cycles", nb, WARM);
    send_pack(8'h11);
    send_pack(8'h22);
    send_pack(8'h33);
    send_pack(8'h44);
    check_idle("a_end");
    repeat (8) tick();
    check_stream("a_stream");

    // Zero length
    start_run(16'h0000);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (trng_en || run_active) seen++;
      tick();
    end
    check("zero_len_enable", seen, 0);
    check_stream("zero_len_stream");
    do_status("zero_len_status");

    // Abort after 5 bytes with a simultaneous packer strobe
    len = 16'($urandom_range(6, 400));
    start_run(len);
    wait_run();
    for (int i = 0; i < 5; i++) send_pack(8'($urandom_range(0, 255)));
    nb = 0;
    while (pack_busy !== 1'b0 && nb < 100) begin
      tick();
      nb++;
    end
    rx_byte = 8'h02;
    rx_valid = 1'b1;
    pack_byte = 8'hA5;
    pack_transmit = 1'b1;
    tick();
    rx_valid = 1'b0;
    pack_transmit = 1'b0;
    model_rem = 0;
    check("abort_no_tx", {31'd0, transmit}, 32'd0);
    check_idle("abort");
    repeat (8) tick();
    check_stream("abort_stream");
    do_status("abort_status");

    // Unknown command, status byte in RUN, forced busy with illegal strobe
    send_rx(8'h7F);
    repeat (4) tick();
    check("unk_run_active", {31'd0, run_active}, 32'd0);
    len = 16'($urandom_range(4, 8));
    start_run(len);
    wait_run();
    send_pack(8'($urandom_range(0, 255)));
    send_pack(8'($urandom_range(0, 255)));
    send_rx(8'h03);
    check("run_ignores_status", {31'd0, run_active}, 32'd1);
    send_pack(8'($urandom_range(0, 255)));
    force_busy = 1'b1;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        pack_byte = 8'($urandom_range(0, 255));
        pack_transmit = 1'b1;
      end
      tick();
      pack_transmit = 1'b0;
      if (pack_busy === 1'b1) nb++;
    end
    check("busy_hold_cycles", nb, 20);
    force_busy = 1'b0;
    for (int i = 3; i < int'(len); i++) send_pack(8'($urandom_range(0, 255)));
    check_idle("d_end");
    repeat (8) tick();
    check_stream("d_stream");
    do_status("d_status");

    // Asynchronous reset in the middle of a 10-byte run
    start_run(16'd10);
    wait_run();
    send_pack(8'($urandom_range(0, 255)));
    send_pack(8'($urandom_range(0, 255)));
    send_pack(8'($urandom_range(0, 255)));
    #2;
    rst = 1'b1;
    #1;
    check("arst_transmit", {31'd0, transmit}, 32'd0);
    check("arst_tx_byte", {24'd0, tx_byte}, 32'd0);
    check("arst_pack_busy", {31'd0, pack_busy}, 32'd1);
    check_idle("arst");
    model_rem = 0;
    model_sent = 0;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pack_busy === 1'b0) send_pack(8'h5A);
      else tick();
    end
    check_idle("arst_after");
    check_stream("arst_stream");
    do_status("arst_status");

    check("tx_spacing", spacing_err, 0);
    check("tx_while_busy", busy_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
